pwm_gate_gen: RTL and testbench
===============================

// Module: pwm_gate_gen
// PURPOSE
//  Three-phase edge-aligned PWM gate generator, directly downstream of the timing hub in clk_ctrl.
//  Compares the hub's pwm_ctr against per-phase duties, double-buffered through a one-deep pending slot
//    (valid/ready, filled by the compute stage) and committed only at PWM period start.
//  Inserts dead time on every leg; forces all gates off on fault.
// PARAMETERS
//  PWM_TICKS       4096  ctrl ticks per PWM period (must match timing hub)
//  DEADTIME_TICKS  16    ctrl ticks both gates of a leg held low on each transition (1..255)
//  DUTY_MAX        4032  accepted duty clamp; duty > DUTY_MAX is stored as DUTY_MAX
// PORTS
//  clk_ctrl       in   1   control clock
//  rst_ctrl       in   1   synchronous active-high reset
//  pwm_ctr        in   12  PWM counter from timing hub
//  pwm_ctr_en     in   1   counter enable from timing hub; low forces gates off
//  fault          in   1   fault from timing hub (level)
//  fault_clr      in   1   clears fault latch (honoured only while fault=0)
//  duty_a/b/c     in   12  duty in ticks, phases A/B/C
//  duty_valid     in   1   duty triple valid
//  duty_ready     out  1   pending slot empty
//  gate_hi        out  3   high-side gates [2:0]=C,B,A
//  gate_lo        out  3   low-side gates [2:0]=C,B,A
//  shadow_loaded  out  1   1-cycle pulse: pending committed to active
//  stale_period   out  1   1-cycle pulse: period started with pending empty
//  stale_cnt      out  8   consecutive stale periods, saturating at 255
//  fault_latched  out  1   sticky fault
// BEHAVIOUR
//  Reset: gate_hi=gate_lo=0, duty_ready=0 in reset then 1, active duties=0, pending empty,
//    shadow_loaded=stale_period=0, stale_cnt=0, fault_latched=0, ctr_q=0, all deadtime counters=0.
//  Handshake: accept when duty_valid&&duty_ready; clamp and store in pending; duty_ready=0 next cycle.
//    Holding duty_valid while not ready has no effect; values need not stay stable.
//  Period start (pstart) = (pwm_ctr==0)&&(ctr_q!=0), ctr_q = pwm_ctr registered. Covers normal wrap
//    and hub re-align zeroing mid-period; a counter frozen at PWM_TICKS-1 produces no pstart.
//  On pstart with pending full: active<=pending, pending empty, duty_ready=1 next cycle,
//    shadow_loaded pulses next cycle, stale_cnt<=0.
//  On pstart with pending empty: active kept, stale_period pulses next cycle, stale_cnt++ (saturating).
//  Accept and pstart in same cycle: pstart commits the old pending contents (or none); new triple
//    lands in pending and waits for the next pstart. Never bypasses pending.
//  Compare (stage 1, registered): raw[x] = pwm_ctr_en && (pwm_ctr < active[x]), 12-bit unsigned.
//    duty 0 -> raw 0 all period; duty DUTY_MAX -> high for DUTY_MAX ticks.
//  Dead time (stage 2, per leg): on raw change, gate_hi=gate_lo=0 and dt counter loads DEADTIME_TICKS;
//    count to 0, then drive gate_hi=raw, gate_lo=~raw. Raw change during dead time reloads counter.
//  Latency: pwm_ctr change -> raw in 1 cycle; steady-state gate edge = raw edge +DEADTIME_TICKS+1.
//  Invariant: gate_hi[x]&gate_lo[x] never 1 in any cycle.
//  Fault: fault=1 sets fault_latched; while fault||fault_latched gates=0 from the next cycle,
//    active duties<=0, pending emptied (duty_ready=1), accepts are discarded.
//  fault_clr && !fault clears the latch; each leg then restarts through a full dead-time interval.
//  pwm_ctr_en=0: gates=0 next cycle, duties and counters held; re-enable restarts through dead time.
//  rst_ctrl mid-operation: all state returns to reset values on the next edge; gates off immediately.
// TESTING
//  T1 DEADTIME=16: accept A=1000, wrap 4095->0 -> shadow_loaded 1 cycle after pstart;
//     gate_hi[0] high ctr 17..1000(+1), gate_lo[0] after 16-tick gap; hi&lo never both 1.
//  T2 two accepts without pstart -> 2nd blocked (duty_ready=0); at pstart duty_ready=1 next cycle.
//  T3 no accept for 3 periods -> stale_period 3 pulses, stale_cnt=3; next load -> stale_cnt=0.
//  T4 duty 4095 -> stored 4032; duty 0 -> gate_lo[x]=1 all period after initial dead time.
//  T5 fault 1 cycle at ctr=500 -> gates 0 next cycle, fault_latched=1; fault_clr -> 16 ticks low,
//     then duty 0 (gate_lo) until a new duty commits at pstart.
//  T6 hub freezes ctr at 4095 for 300 cycles then zeroes -> exactly one pstart, one commit.

Source files
------------

// File: rtl/pwm_gate_gen_if.sv
// Duty-triple handshake between the compute stage and the PWM gate generator.
// Master offers a clamped-later duty triple; slave signals an empty pending slot.
interface pwm_gate_gen_if;
  logic [11:0] duty_a;
  logic [11:0] duty_b;
  logic [11:0] duty_c;
  logic        duty_valid;
  logic        duty_ready;

  modport master (
    output duty_a, duty_b, duty_c, duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_a, duty_b, duty_c, duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_gate_gen.sv
// Three-phase edge-aligned PWM gate generator with shadowed duties,
// per-leg dead time and fault shutdown.
module pwm_gate_gen #(
  parameter int PWM_TICKS      = 4096,
  parameter int DEADTIME_TICKS = 16,
  parameter int DUTY_MAX       = 4032
) (
  input  logic                clk_ctrl,
  input  logic                rst_ctrl,
  input  logic [11:0]         pwm_ctr,
  input  logic                pwm_ctr_en,
  input  logic                fault,
  input  logic                fault_clr,
  pwm_gate_gen_if.slave       duty_if,
  output logic [2:0]          gate_hi,
  output logic [2:0]          gate_lo,
  output logic                shadow_loaded,
  output logic                stale_period,
  output logic [7:0]          stale_cnt,
  output logic                fault_latched
);

  localparam int DMAX_I =
    (DUTY_MAX > PWM_TICKS - 1) ? PWM_TICKS - 1 : DUTY_MAX;
  localparam logic [11:0] DMAX = 12'(DMAX_I);
  localparam logic [7:0]  DT   = 8'(DEADTIME_TICKS);

  function automatic logic [11:0] clamp(input logic [11:0] d);
    return (d > DMAX) ? DMAX : d;
  endfunction

  logic [11:0]      ctr_q;
  logic [2:0][11:0] pend_q, pend_d;
  logic             pfull_q, pfull_d;
  logic             rdy_q, rdy_d;
  logic [2:0][11:0] act_q, act_d;
  logic             ld_q, ld_d;
  logic             stl_q, stl_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             flat_q, flat_d;
  logic [2:0]       raw_q, raw_d;
  logic [2:0]       rawd_q, rawd_d;
  logic [2:0][7:0]  dt_q, dt_d;
  logic [2:0]       hi_q, hi_d;
  logic [2:0]       lo_q, lo_d;

  logic flt;
  logic pstart;
  logic accept;
  logic force_off;

  assign flt       = fault | flat_q;
  assign pstart    = (pwm_ctr == 12'd0) && (ctr_q != 12'd0);
  assign accept    = duty_if.duty_valid && rdy_q && !flt;
  assign force_off = flt || !pwm_ctr_en;

  always_comb begin
    pend_d  = pend_q;
    pfull_d = pfull_q;
    act_d   = act_q;
    ld_d    = 1'b0;
    stl_d   = 1'b0;
    scnt_d  = scnt_q;
    flat_d  = flat_q;
    if (fault) begin
      flat_d = 1'b1;
    end else if (fault_clr) begin
      flat_d = 1'b0;
    end
    // Commit uses the old pending contents; a same-cycle accept refills it.
    if (pstart) begin
      if (pfull_q) begin
        act_d   = pend_q;
        pfull_d = 1'b0;
        ld_d    = 1'b1;
        scnt_d  = 8'd0;
      end else begin
        stl_d = 1'b1;
        if (scnt_q != 8'hFF) begin
          scnt_d = scnt_q + 8'd1;
        end
      end
    end
    if (accept) begin
      pend_d[0] = clamp(duty_if.duty_a);
      pend_d[1] = clamp(duty_if.duty_b);
      pend_d[2] = clamp(duty_if.duty_c);
      pfull_d   = 1'b1;
    end
    if (flt) begin
      act_d   = '0;
      pfull_d = 1'b0;
    end
    rdy_d = !pfull_d;
  end

  always_comb begin
    raw_d  = '0;
    rawd_d = raw_q;
    dt_d   = dt_q;
    hi_d   = '0;
    lo_d   = '0;
    for (int i = 0; i < 3; i++) begin
      raw_d[i] = pwm_ctr_en && (pwm_ctr < act_q[i]);
      // Forced-off legs preload the dead time so release always waits it out.
      if (force_off || (raw_q[i] != rawd_q[i])) begin
        dt_d[i] = DT;
      end else if (dt_q[i] > 8'd1) begin
        dt_d[i] = dt_q[i] - 8'd1;
      end else begin
        dt_d[i] = 8'd0;
        hi_d[i] = raw_q[i];
        lo_d[i] = !raw_q[i];
      end
    end
  end

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      ctr_q   <= '0;
      pend_q  <= '0;
      pfull_q <= 1'b0;
      rdy_q   <= 1'b0;
      act_q   <= '0;
      ld_q    <= 1'b0;
      stl_q   <= 1'b0;
      scnt_q  <= '0;
      flat_q  <= 1'b0;
      raw_q   <= '0;
      rawd_q  <= '0;
      dt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      ctr_q   <= pwm_ctr;
      pend_q  <= pend_d;
      pfull_q <= pfull_d;
      rdy_q   <= rdy_d;
      act_q   <= act_d;
      ld_q    <= ld_d;
      stl_q   <= stl_d;
      scnt_q  <= scnt_d;
      flat_q  <= flat_d;
      raw_q   <= raw_d;
      rawd_q  <= rawd_d;
      dt_q    <= dt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign duty_if.duty_ready = rdy_q;
  assign gate_hi       = hi_q & {3{~rst_ctrl}};
  assign gate_lo       = lo_q & {3{~rst_ctrl}};
  assign shadow_loaded = ld_q;
  assign stale_period  = stl_q;
  assign stale_cnt     = scnt_q;
  assign fault_latched = flat_q;

endmodule

// File: tb/tb_pwm_gate_gen.sv
// Bench for pwm_gate_gen: directed counter sweeps, period events
// checked through a scoreboard queue, gate timing checked in-line.
module tb_pwm_gate_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pwm_ctr = '0;
  logic        en = 1'b1;
  logic        fault = 1'b0;
  logic        fault_clr = 1'b0;
  logic [2:0]  gate_hi, gate_lo;
  logic        shadow_loaded, stale_period;
  logic [7:0]  stale_cnt;
  logic        fault_latched;

  pwm_gate_gen_if dif ();

  pwm_gate_gen dut (
    .clk_ctrl      (clk),
    .rst_ctrl      (rst),
    .pwm_ctr       (pwm_ctr),
    .pwm_ctr_en    (en),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .duty_if       (dif.slave),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .shadow_loaded (shadow_loaded),
    .stale_period  (stale_period),
    .stale_cnt     (stale_cnt),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         load;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit load, input int cnt);
    ev_t e;
    e.load = load;
    e.cnt  = 8'(cnt);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int v);
    pwm_ctr = 12'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int a, input int b);
    for (int v = a; v <= b; v++) tick(v);
  endtask

  task automatic accept(input int a, input int b, input int c);
    dif.duty_a     = 12'(a);
    dif.duty_b     = 12'(b);
    dif.duty_c     = 12'(c);
    dif.duty_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.duty_valid = 1'b0;
  endtask

  // Monitor: period events against the scoreboard, leg exclusivity always.
  always @(negedge clk) begin
    if (!rst) begin
      chk("hi_lo_excl", {29'd0, gate_hi & gate_lo}, 32'd0);
      if (shadow_loaded || stale_period) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event ld=%0b st=%0b want=none t=%0t",
                   shadow_loaded, stale_period, $time);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_load", {31'd0, shadow_loaded}, {31'd0, e.load});
          chk("ev_stale", {31'd0, stale_period}, {31'd0, !e.load});
          chk("ev_cnt", {24'd0, stale_cnt}, {24'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    dif.duty_a     = '0;
    dif.duty_b     = '0;
    dif.duty_c     = '0;
    dif.duty_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, dif.duty_ready}, 0);
    chk("rst_hi", {29'd0, gate_hi}, 0);
    chk("rst_lo", {29'd0, gate_lo}, 0);
    chk("rst_scnt", {24'd0, stale_cnt}, 0);
    chk("rst_flt", {31'd0, fault_latched}, 0);
    rst = 1'b0;
    tick(0);
    chk("post_rst_ready", {31'd0, dif.duty_ready}, 1);

    // T1: single commit and dead-time timing on leg A
    accept(1000, 0, 0);
    chk("t1_rdy_low", {31'd0, dif.duty_ready}, 0);
    tick(4095);
    push(1'b1, 0);
    tick(0);
    chk("t1_rdy_back", {31'd0, dif.duty_ready}, 1);
    tick(1);
    chk("t1_lo_before", {31'd0, gate_lo[0]}, 1);
    tick(2);
    chk("t1_gap_start", {30'd0, gate_hi[0], gate_lo[0]}, 0);
    run(3, 17);
    chk("t1_hi_17", {31'd0, gate_hi[0]}, 0);
    tick(18);
    chk("t1_hi_18", {30'd0, gate_hi[0], gate_lo[0]}, 2);
    run(19, 1000);
    chk("t1_hi_1000", {31'd0, gate_hi[0]}, 1);
    tick(1001);
    chk("t1_gap2", {30'd0, gate_hi[0], gate_lo[0]}, 0);
    run(1002, 1016);
    chk("t1_lo_1016", {31'd0, gate_lo[0]}, 0);
    tick(1017);
    chk("t1_lo_all", {29'd0, gate_lo}, 7);
    chk("t1_hi_none", {29'd0, gate_hi}, 0);

    // T2: second triple blocked while pending is full
    accept(1000, 200, 0);
    chk("t2_rdy0", {31'd0, dif.duty_ready}, 0);
    accept(3000, 3000, 3000);
    chk("t2_blocked", {31'd0, dif.duty_ready}, 0);
    tick(5);
    push(1'b1, 0);
    tick(0);
    chk("t2_rdy1", {31'd0, dif.duty_ready}, 1);
    run(1, 300);
    chk("t2_hi_300", {29'd0, gate_hi}, 1);
    chk("t2_lo_300", {29'd0, gate_lo}, 6);

    // T3: three stale periods, then a load resets the count
    push(1'b0, 1);
    tick(0);
    tick(5);
    push(1'b0, 2);
    tick(0);
    tick(5);
    push(1'b0, 3);
    tick(0);
    chk("t3_scnt3", {24'd0, stale_cnt}, 3);
    accept(4095, 0, 0);
    tick(5);
    push(1'b1, 0);
    tick(0);
    chk("t3_scnt0", {24'd0, stale_cnt}, 0);

    // T4: 4095 clamps to 4032, zero duty keeps low side on
    run(1, 4032);
    chk("t4_hi_4032", {31'd0, gate_hi[0]}, 1);
    tick(4033);
    chk("t4_hi_4033", {31'd0, gate_hi[0]}, 0);
    run(4034, 4095);
    chk("t4_lo_end", {29'd0, gate_lo}, 7);

    // T5: fault shutdown, discarded accept, clear through dead time
    push(1'b0, 1);
    tick(0);
    run(1, 499);
    chk("t5_hi_499", {31'd0, gate_hi[0]}, 1);
    fault = 1'b1;
    tick(500);
    fault = 1'b0;
    chk("t5_off_hi", {29'd0, gate_hi}, 0);
    chk("t5_off_lo", {29'd0, gate_lo}, 0);
    chk("t5_latched", {31'd0, fault_latched}, 1);
    run(501, 510);
    chk("t5_still_off", {26'd0, gate_hi, gate_lo}, 0);
    chk("t5_rdy", {31'd0, dif.duty_ready}, 1);
    accept(2000, 2000, 2000);
    chk("t5_discard", {31'd0, dif.duty_ready}, 1);
    run(511, 529);
    fault_clr = 1'b1;
    tick(530);
    fault_clr = 1'b0;
    chk("t5_cleared", {31'd0, fault_latched}, 0);
    run(531, 545);
    chk("t5_dt_545", {26'd0, gate_hi, gate_lo}, 0);
    tick(546);
    chk("t5_lo_546", {26'd0, gate_hi, gate_lo}, 7);
    push(1'b0, 2);
    tick(0);
    run(1, 40);
    chk("t5_duty0", {26'd0, gate_hi, gate_lo}, 7);

    // T6: frozen counter gives exactly one period start
    accept(100, 0, 0);
    repeat (300) tick(4095);
    push(1'b1, 0);
    tick(0);
    chk("t6_scnt", {24'd0, stale_cnt}, 0);
    run(1, 50);
    chk("t6_hi_50", {31'd0, gate_hi[0]}, 1);
    en = 1'b0;
    tick(51);
    chk("en_off", {26'd0, gate_hi, gate_lo}, 0);
    run(52, 59);
    en = 1'b1;
    tick(60);
    run(61, 76);
    chk("en_dt_76", {31'd0, gate_hi[0]}, 0);
    tick(77);
    chk("en_hi_77", {31'd0, gate_hi[0]}, 1);

    // Mid-run reset
    rst = 1'b1;
    #1;
    chk("rst_gate_now", {26'd0, gate_hi, gate_lo}, 0);
    @(posedge clk);
    #1;
    chk("rst2_ready", {31'd0, dif.duty_ready}, 0);
    chk("rst2_scnt", {24'd0, stale_cnt}, 0);
    rst = 1'b0;
    tick(0);
    chk("rst2_rdy1", {31'd0, dif.duty_ready}, 1);
    chk("rst2_lo", {26'd0, gate_hi, gate_lo}, 7);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
